// File: rtl/fp_mult_pkg.sv
// Shared types for the two-requester FP32 multiplier front end.
// Request and result records travel through the pipeline as packed structs.
package fp_mult_pkg;

    localparam int DEF_TAG_W = 4;
    localparam int DEF_CNT_W = 16;

    typedef logic [31:0]          fp32_t;
    typedef logic [DEF_TAG_W-1:0] tag_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
        tag_t  tag;
        logic  src;
    } mult_req_t;

    typedef struct packed {
        fp32_t data;
        logic  ovf;
        logic  udf;
        tag_t  tag;
        logic  src;
    } mult_res_t;

    localparam fp32_t QNAN = 32'h7FC0_0000;

    function automatic logic is_nan(input fp32_t x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/mult.sv
// Combinational FP32 multiplier, round-to-nearest-even.
// Subnormal inputs and results flush to signed zero; overflow saturates to infinity.
module mult
    import fp_mult_pkg::*;
(
    input  fp32_t A,
    input  fp32_t B,
    output fp32_t result,
    output logic  overflow,
    output logic  underflow
);

    logic        sign_s;
    logic [7:0]  ea_s, eb_s;
    logic [47:0] prod_s;
    logic [22:0] frac_s;
    logic        guard_s, sticky_s, rnd_s;
    logic [23:0] frac_rnd_s;
    logic [9:0]  e_fin_s;

    // Mantissa product, normalisation, rounding and special-case selection
    always_comb begin
        sign_s    = A[31] ^ B[31];
        ea_s      = A[30:23];
        eb_s      = B[30:23];
        prod_s    = 48'({1'b1, A[22:0]}) * 48'({1'b1, B[22:0]});
        if (prod_s[47]) begin
            frac_s   = prod_s[46:24];
            guard_s  = prod_s[23];
            sticky_s = |prod_s[22:0];
        end else begin
            frac_s   = prod_s[45:23];
            guard_s  = prod_s[22];
            sticky_s = |prod_s[21:0];
        end
        rnd_s      = guard_s & (sticky_s | frac_s[0]);
        frac_rnd_s = {1'b0, frac_s} + {23'd0, rnd_s};
        // Biased exponent sum still carries an extra +127; compared against 127 and 382
        e_fin_s    = {2'b00, ea_s} + {2'b00, eb_s} + {9'd0, prod_s[47]} + {9'd0, frac_rnd_s[23]};
        result     = 32'd0;
        overflow   = 1'b0;
        underflow  = 1'b0;
        if (is_nan(A) || is_nan(B) ||
            ((ea_s == 8'hFF) && (eb_s == 8'h00)) || ((eb_s == 8'hFF) && (ea_s == 8'h00))) begin
            result = QNAN;
        end else if ((ea_s == 8'hFF) || (eb_s == 8'hFF)) begin
            result = {sign_s, 8'hFF, 23'd0};
        end else if ((ea_s == 8'h00) || (eb_s == 8'h00)) begin
            result = {sign_s, 31'd0};
        end else if (e_fin_s >= 10'd382) begin
            result   = {sign_s, 8'hFF, 23'd0};
            overflow = 1'b1;
        end else if (e_fin_s <= 10'd127) begin
            result    = {sign_s, 31'd0};
            underflow = 1'b1;
        end else begin
            result = {sign_s, 8'(e_fin_s - 10'd127), frac_rnd_s[22:0]};
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is consumed.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic rr_r;

    // Grant selection: a lone requester wins, a tie goes to the pointer
    always_comb begin
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer update: after serving requester N, favour the other one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r <= 1'b0;
        end else if (en && (grant != 2'b00)) begin
            rr_r <= grant[0];
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Two requesters share one FP32 multiplier through a 2-stage stallable pipeline,
// with saturating overflow/underflow event counters.
module fp_mult_arbiter
    import fp_mult_pkg::*;
#(
    parameter int TAG_W = DEF_TAG_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_ovf,
    output logic             res_udf,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] udf_cnt
);

    logic             adv1_s, adv2_s, xfer_s, hs_s;
    logic [1:0]       grant_s;
    logic             s1_valid_r, s2_valid_r;
    mult_req_t        req_s, s1_r;
    mult_res_t        s2_r;
    fp32_t            prod_s;
    logic             ovf_s, udf_s;
    logic [CNT_W-1:0] ovf_cnt_r, udf_cnt_r;

    assign adv2_s = ~s2_valid_r | res_ready;
    assign adv1_s = ~s1_valid_r | adv2_s;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1_valid, req0_valid}),
        .en    (adv1_s),
        .grant (grant_s)
    );

    assign req0_ready = adv1_s & grant_s[0];
    assign req1_ready = adv1_s & grant_s[1];
    assign xfer_s     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign hs_s       = s2_valid_r & res_ready;

    // Operand mux for whichever requester holds the grant
    always_comb begin
        if (grant_s[1]) begin
            req_s = '{a: req1_a, b: req1_b, tag: req1_tag, src: 1'b1};
        end else begin
            req_s = '{a: req0_a, b: req0_b, tag: req0_tag, src: 1'b0};
        end
    end

    // Stage 1: operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else if (adv1_s) begin
            s1_valid_r <= xfer_s;
            if (xfer_s) s1_r <= req_s;
        end
    end

    mult u_mult (
        .A         (s1_r.a),
        .B         (s1_r.b),
        .result    (prod_s),
        .overflow  (ovf_s),
        .underflow (udf_s)
    );

    // Stage 2: result register, which drives the res_* port directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_r       <= '0;
        end else if (adv2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) s2_r <= '{data: prod_s, ovf: ovf_s, udf: udf_s, tag: s1_r.tag, src: s1_r.src};
        end
    end

    // Saturating exception counters; clear beats a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_r <= {CNT_W{1'b0}};
            udf_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            ovf_cnt_r <= {CNT_W{1'b0}};
            udf_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (hs_s && s2_r.ovf && !(&ovf_cnt_r)) ovf_cnt_r <= ovf_cnt_r + CNT_W'(1);
            if (hs_s && s2_r.udf && !(&udf_cnt_r)) udf_cnt_r <= udf_cnt_r + CNT_W'(1);
        end
    end

    assign res_valid = s2_valid_r;
    assign res_data  = s2_r.data;
    assign res_ovf   = s2_r.ovf;
    assign res_udf   = s2_r.udf;
    assign res_src   = s2_r.src;
    assign res_tag   = s2_r.tag;
    assign ovf_cnt   = ovf_cnt_r;
    assign udf_cnt   = udf_cnt_r;

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one combinational FP32 multiplier instance, `mult` (ports A, B, result, overflow, underflow), between two requesters.
- Each requester has its own valid/ready port. A single result port carries valid/ready handshaking.
- Operands and results are registered around the multiplier, giving a 2-stage stallable pipeline. Arbitration is round-robin.
- Saturating counters record exceptions for the software status path.

Parameters:
- TAG_W, 4, width of the per-request tag passed through unchanged to the result.
- CNT_W, 16, width of the overflow and underflow event counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 holds a valid operand pair.
- req0_ready  out  1  requester 0 transfer is accepted this cycle.
- req0_a, req0_b  in  32  IEEE-754 single-precision operands.
- req0_tag  in  TAG_W  requester 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_tag  same roles for requester 1.
- res_valid  out  1  result is valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  32  product from `mult`.
- res_ovf, res_udf  out  1  overflow and underflow flags from `mult`.
- res_src  out  1  requester that issued the operation (0 or 1).
- res_tag  out  TAG_W  tag of that request.
- clr_cnt  in  1  synchronous clear of both counters.
- ovf_cnt, udf_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid=0, s2_valid=0, so res_valid=0.
  - Round-robin pointer rr=0, meaning requester 0 is favoured.
  - ovf_cnt=0, udf_cnt=0. res_data, res_ovf, res_udf, res_src and res_tag read 0.
  - Reset mid-operation discards every in-flight operation. Nothing is replayed.
- Pipeline stalling:
  - adv2 = ~s2_valid | res_ready.
  - adv1 = ~s1_valid | adv2.
- Arbitration (combinational from the valids):
  - Only one requester valid: it gets the grant.
  - Both valid: the grant goes to the requester that rr points at.
  - reqN_ready = adv1 & grantN. At most one ready is high per cycle.
  - Ready may depend on valid. Valid must not depend on ready.
  - A transfer happens when reqN_valid & reqN_ready.
- rr update:
  - On a transfer from requester N, rr becomes ~N.
  - With no transfer, rr holds, including under stall.
- Stage 1: on adv1, s1 captures {a, b, tag, src} of the granted transfer. s1_valid = (any transfer).
- Stage 2: on adv2, s2 captures {result, overflow, underflow} from `mult`, driven by s1 operands, together with s1 tag and src. s2_valid = s1_valid.
- Latency and throughput:
  - A transfer at edge k produces res_valid high after edge k+2, provided res_ready has stayed high.
  - Throughput is one operation per cycle.
- Stall:
  - While res_valid & ~res_ready, every res_* output holds stable.
  - The stall propagates back: the s1 slot fills, then both readies go low.
- Ordering: results leave in acceptance order. No operation is dropped or duplicated.
- Counters:
  - On a result handshake (res_valid & res_ready), ovf_cnt increments if res_ovf and udf_cnt increments if res_udf.
  - Both saturate at all-ones.
  - clr_cnt sets both to 0 and wins over a simultaneous increment.
- Arithmetic: the block does not modify operands or results. IEEE semantics are whatever `mult` provides.

Decomposition:
- Shared package fp_mult_pkg holds:
  - typedef fp32_t (32-bit logic);
  - struct mult_req_t {a, b, tag, src};
  - struct mult_res_t {data, ovf, udf, tag, src}.
- One natural sub-module: rr_arb2, the 2-way round-robin arbiter that produces the grant and the rr pointer update.
- `mult` is instantiated unchanged between s1 and s2.

Test Plan:
- Single request, res_ready=1: requester 0 sends 0x40000000 × 0x40400000 with tag 3 -> res_valid 2 cycles later with res_data=0x40C00000, src=0, tag=3, ovf=udf=0.
- Contention: both requesters valid continuously for 6 cycles from reset -> grants alternate 0,1,0,1,0,1 and results arrive in the same order.
- Backpressure: res_ready=0 for 5 cycles while requests stream -> res_* stable throughout, readies low after 2 accepted ops, no loss or duplication after res_ready=1 returns (compare against a FIFO scoreboard).
- Values and counter: requester 1 sends 0x3FC00000 × 0x3FC00000 -> 0x40100000. A bench model of `mult` predicts every flag. udf_cnt increments once per flagged handshake, and pre-loading counts to 0xFFFF saturates them.
- Counter clear: clr_cnt asserted in the same cycle as a flagged handshake -> counter reads 0 next cycle.
- Reset mid-stream: rst_n low while s1 and s2 are full -> res_valid=0 and counters=0 immediately, rr=0, and the first operation after release completes normally.
